serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised multi-cycle N-bit subtractor, built from a BITS_PER_CYCLE-wide full-subtractor slice and a registered borrow chain.
- Computes d = a - b - bin over WIDTH/BITS_PER_CYCLE clock cycles, LSB chunk first, using a start/busy/done handshake.
- Successor to the single-bit combinational full subtractor: it adds width generality, an area/latency trade-off, borrow-out and signed overflow.
- Used wherever a narrow datapath must subtract wide operands.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- BITS_PER_CYCLE, 1, bits processed per clock; must divide WIDTH exactly. Elaboration fails otherwise.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request pulse, sampled on the rising edge.
- a  input  WIDTH  minuend, captured when start is accepted.
- b  input  WIDTH  subtrahend, captured when start is accepted.
- bin  input  1  borrow-in, captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- d  output  WIDTH  difference (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow out of the MSB (1 when a < b + bin, unsigned).
- ovf  output  1  two's-complement overflow of the signed subtraction.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, d=0, bout=0, ovf=0. Internal step counter, operand registers and borrow register are cleared.
- Constant N = WIDTH/BITS_PER_CYCLE.
- State IDLE, busy=0:
  - start=1 at an edge latches a, b and bin, clears step to 0, and moves to RUN.
  - busy goes high after that same edge.
- State RUN, busy=1:
  - Each edge processes chunk[step], bits step*BPC .. step*BPC+BPC-1.
  - Chunk difference = a_chunk - b_chunk - borrow_reg. The chunk result shifts into the internal result register; the new borrow is stored; step increments.
  - On the edge processing chunk N-1:
    - d, bout and ovf are loaded from the internal result.
    - done is set to 1 and busy to 0.
    - The state returns to IDLE.
- Latency: done is high in the cycle following the Nth edge after the accepting edge. Example: WIDTH=8, BPC=1 gives 8 edges; BPC=4 gives 2 edges.
- done is high for exactly one cycle, then drops to 0.
- d, bout and ovf hold their value until the next completion. They never show partial results during RUN.
- ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), using the captured a and b. bin is included in d.
- start while busy=1 is ignored. The operation in flight and its operands are not disturbed.
- Back-to-back: start=1 in the cycle where done=1 is accepted, because busy=0 then. done still falls the next cycle; busy rises.
- Operand inputs may change freely after the accepting edge.
- Reset asserted mid-RUN aborts immediately to reset values. No done pulse is produced for the aborted operation.
- Boundary values:
  - a=b, bin=0 gives d=0, bout=0.
  - a=0, b=2^WIDTH-1, bin=1 gives d=0, bout=1.

Test Plan (WIDTH=8, BITS_PER_CYCLE=1 unless noted):
- Reset: pulse rst_n low asynchronously mid-cycle -> busy=0, done=0, d=0x00, bout=0, ovf=0, immediately and without waiting for a clock edge.
- Basic op: start with a=0x05, b=0x03, bin=0 -> busy=1 for 8 cycles; done pulses once on cycle 8; d=0x02, bout=0, ovf=0. d stays 0x00 until done.
- Underflow and borrow-in: a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 -> d=0xFF, bout=1, ovf=0.
- Signed overflow: a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> d=0x80, bout=1, ovf=1.
- Handshake:
  - Start a=0x10, b=0x01.
  - Pulse start with a=0xAA, b=0x55 at cycle 3 of RUN -> ignored; result is d=0x0F.
  - Assert start with a=0x20, b=0x20 in the done cycle -> accepted; 8 cycles later d=0x00, bout=0.
- Reset mid-operation and wide config:
  - Drop rst_n at RUN cycle 4 -> no done; outputs are zero. A following op with a=0x09, b=0x04 gives d=0x05.
  - Rerun with WIDTH=16, BITS_PER_CYCLE=4 and a=0x1234, b=0x0235 -> done after 4 cycles, d=0x0FFF, bout=0, ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Multi-cycle d = a - b - bin, BITS_PER_CYCLE bits per clock, LSB chunk first; done pulses WIDTH/BITS_PER_CYCLE clocks after start is accepted.
// No backpressure: start is accepted only while idle (including the done cycle) and ignored while busy.
module serial_subtractor #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    generate
        if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
            $error("serial_subtractor: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_n;
    logic [WIDTH-1:0]        a_q, b_q, res_q, res_n;
    logic                    borrow_q;
    logic [SW-1:0]           step;
    logic [BITS_PER_CYCLE:0] chunk;
    logic                    last;
    int                      lsb;

    assign last = (step == LAST);
    assign busy = (state == RUN);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Top bit of the (BPC+1)-bit difference is the chunk's borrow out.
    always_comb begin
        lsb   = int'(step) * BITS_PER_CYCLE;
        res_n = res_q;
        chunk = {1'b0, a_q[lsb +: BITS_PER_CYCLE]}
              - {1'b0, b_q[lsb +: BITS_PER_CYCLE]}
              - {{BITS_PER_CYCLE{1'b0}}, borrow_q};
        res_n[lsb +: BITS_PER_CYCLE] = chunk[BITS_PER_CYCLE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            step     <= '0;
            done     <= 1'b0;
            d        <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_q      <= a;
                    b_q      <= b;
                    borrow_q <= bin;
                    res_q    <= '0;
                    step     <= '0;
                end
            end else begin
                res_q    <= res_n;
                borrow_q <= chunk[BITS_PER_CYCLE];
                step     <= step + 1'b1;
                // Outputs are only touched on the final chunk so they never show partial results.
                if (last) begin
                    d    <= res_n;
                    bout <= chunk[BITS_PER_CYCLE];
                    ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_n[WIDTH-1] != a_q[WIDTH-1]);
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 8-bit/1-bit-per-cycle and 16-bit/4-bits-per-cycle instances.
module tb_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, bin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, bout8, ovf8;
    logic [7:0]  d8;
    logic        start16 = 1'b0, bin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, bout16, ovf16;
    logic [15:0] d16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .d(d16), .bout(bout16), .ovf(ovf16)
    );

    // Starts one 8-bit op and returns in the done cycle; cycles = -1 on timeout.
    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          output int cycles);
        @(posedge clk); #1;
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'hC3; b8 = 8'h3C; bin8 = 1'b1;
        cycles = 0;
        while (!done8 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!done8) cycles = -1;
    endtask

    task automatic test_reset;
        #3;
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done8); end
        total++; if ({d8, bout8, ovf8} !== 10'h000) begin bad++; $display("FAIL reset_outs got d=%h bout=%b ovf=%b want 00/0/0", d8, bout8, ovf8); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int  cycles;
        bit  leak;
        leak = 1'b0;
        @(posedge clk); #1;
        a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy8); end
        cycles = 0;
        while (!done8 && cycles < 40) begin
            if (d8 !== 8'h00) leak = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        total++; if (cycles !== 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", cycles); end
        total++; if (leak !== 1'b0) begin bad++; $display("FAIL basic_no_partial got=%b want=0", leak); end
        total++; if ({d8, bout8, ovf8, busy8} !== {8'h02, 1'b0, 1'b0, 1'b0}) begin bad++; $display("FAIL basic_result got d=%h bout=%b ovf=%b busy=%b want 02/0/0/0", d8, bout8, ovf8, busy8); end
        @(posedge clk); #1;
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done8); end
        total++; if (d8 !== 8'h02) begin bad++; $display("FAIL basic_hold got=%h want=02", d8); end
    endtask

    task automatic test_vectors;
        logic [7:0] va [6] = '{8'h00, 8'h00, 8'h80, 8'h7F, 8'h5A, 8'h00};
        logic [7:0] vb [6] = '{8'h01, 8'h00, 8'h01, 8'hFF, 8'h5A, 8'hFF};
        logic       vi [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
        logic [7:0] ed [6] = '{8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'h00};
        logic       eb [6] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        logic       eo [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        int cycles;
        for (int i = 0; i < 6; i++) begin
            do_op8(va[i], vb[i], vi[i], cycles);
            total++;
            if (cycles !== 8 || {d8, bout8, ovf8} !== {ed[i], eb[i], eo[i]}) begin
                bad++;
                $display("FAIL vec%0d got cyc=%0d d=%h bout=%b ovf=%b want cyc=8 d=%h bout=%b ovf=%b",
                         i, cycles, d8, bout8, ovf8, ed[i], eb[i], eo[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cycles;
        @(posedge clk); #1;
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cycles = 3;
        while (!done8 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        total++; if (cycles !== 8 || d8 !== 8'h0F || bout8 !== 1'b0) begin bad++; $display("FAIL ignored_start got cyc=%0d d=%h bout=%b want cyc=8 d=0f bout=0", cycles, d8, bout8); end
        a8 = 8'h20; b8 = 8'h20; bin8 = 1'b0; start8 = 1'b1;
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL b2b_idle_in_done got busy=%b want=0", busy8); end
        @(posedge clk); #1;
        start8 = 1'b0;
        total++; if ({done8, busy8} !== 2'b01) begin bad++; $display("FAIL b2b_accept got done=%b busy=%b want 0/1", done8, busy8); end
        cycles = 0;
        while (!done8 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        total++; if (cycles !== 8 || d8 !== 8'h00 || bout8 !== 1'b0) begin bad++; $display("FAIL b2b_result got cyc=%0d d=%h bout=%b want cyc=8 d=00 bout=0", cycles, d8, bout8); end
    endtask

    task automatic test_reset_mid;
        int cycles;
        bit saw_done;
        do_op8(8'h00, 8'h01, 1'b0, cycles);
        @(posedge clk); #1;
        a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if ({busy8, done8, d8, bout8, ovf8} !== 12'h000) begin bad++; $display("FAIL midreset_outs got busy=%b done=%b d=%h bout=%b ovf=%b want all 0", busy8, done8, d8, bout8, ovf8); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL midreset_no_done got=%b want=0", saw_done); end
        do_op8(8'h09, 8'h04, 1'b0, cycles);
        total++; if (cycles !== 8 || d8 !== 8'h05) begin bad++; $display("FAIL midreset_next got cyc=%0d d=%h want cyc=8 d=05", cycles, d8); end
    endtask

    task automatic test_wide;
        int cycles;
        @(posedge clk); #1;
        a16 = 16'h1234; b16 = 16'h0235; bin16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h0000;
        cycles = 0;
        while (!done16 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        total++; if (cycles !== 4) begin bad++; $display("FAIL wide_latency got=%0d want=4", cycles); end
        total++; if ({d16, bout16, ovf16} !== {16'h0FFF, 1'b0, 1'b0}) begin bad++; $display("FAIL wide_result got d=%h bout=%b ovf=%b want 0fff/0/0", d16, bout16, ovf16); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_vectors;
        test_back_to_back;
        test_reset_mid;
        test_wide;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
